// File: rtl/id_token_tracker_pkg.sv
// Shared definitions for the identifier token tracker: ASCII bounds, char classes, mirror states.
package id_token_tracker_pkg;

  localparam int unsigned LEN_W_DEF = 6;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned CNT_W_DEF = 16;

  localparam logic [7:0] ASCII_UC_A = 8'h41;
  localparam logic [7:0] ASCII_UC_Z = 8'h5A;
  localparam logic [7:0] ASCII_LC_A = 8'h61;
  localparam logic [7:0] ASCII_LC_Z = 8'h7A;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_9    = 8'h39;

  typedef enum logic [1:0] {
    CLS_O = 2'd0,
    CLS_L = 2'd1,
    CLS_D = 2'd2
  } char_cls_e;

  // Numbering matches the upstream recogniser so the two machines can be compared directly.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALPHA = 2'd1,
    S_DIGIT = 2'd2
  } mirror_state_e;

  function automatic char_cls_e char_class(input logic [7:0] c);
    if ((c >= ASCII_UC_A && c <= ASCII_UC_Z) || (c >= ASCII_LC_A && c <= ASCII_LC_Z))
      return CLS_L;
    if (c >= ASCII_0 && c <= ASCII_9)
      return CLS_D;
    return CLS_O;
  endfunction

endpackage

// File: rtl/id_token_tracker_if.sv
// Token length stream (valid/ready) between the tracker and its consumer.
interface id_token_tracker_if #(
  parameter int unsigned LEN_W = 6
);
  logic [LEN_W-1:0] tok_len;
  logic             tok_valid;
  logic             tok_ready;

  modport master (output tok_len, output tok_valid, input tok_ready);
  modport slave  (input tok_len, input tok_valid, output tok_ready);
endinterface

// File: rtl/id_len_fifo.sv
// Small FIFO for completed token lengths; head, empty and full are registered.
module id_len_fifo #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic             push_ok, pop_ok, empty_n, full_n;
  logic [WIDTH-1:0] dout_n;

  // A pop on a full FIFO frees the slot the same-edge push lands in.
  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_n = wr_ptr + PW'(push_ok);
    rd_ptr_n = rd_ptr + PW'(pop_ok);
    empty_n  = (wr_ptr_n == rd_ptr_n);
    full_n   = (wr_ptr_n[AW] != rd_ptr_n[AW]) && (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
    dout_n   = (push_ok && (wr_ptr[AW-1:0] == rd_ptr_n[AW-1:0])) ? din
                                                                 : mem[rd_ptr_n[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      dout   <= '0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      empty  <= empty_n;
      full   <= full_n;
      dout   <= dout_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/id_token_tracker.sv
// Measures and counts identifiers (letter run then digit run) and queues their lengths.
// Optional match cross-check against an internal mirror: define ID_TRK_XCHECK_EN.
module id_token_tracker
  import id_token_tracker_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          char,
  input  logic                match,
  id_token_tracker_if.master  tok,
  output logic [CNT_W-1:0]    tok_cnt,
  output logic                ovf,
  output logic                err
);
  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

  mirror_state_e    state, state_n;
  logic [LEN_W-1:0] len, len_n, len_inc;
  char_cls_e        cls;
  logic             emit;
  logic             fifo_full, fifo_empty, pop_eff;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      len   <= '0;
    end else begin
      state <= state_n;
      len   <= len_n;
    end
  end

  // Mirror of the recogniser plus saturating run length.
  always_comb begin
    cls     = char_class(char);
    len_inc = (len == LEN_MAX) ? len : len + LEN_W'(1);
    state_n = S_IDLE;
    len_n   = '0;
    emit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (cls == CLS_L) begin
          state_n = S_ALPHA;
          len_n   = LEN_W'(1);
        end
      end
      S_ALPHA: begin
        if (cls == CLS_L) begin
          state_n = S_ALPHA;
          len_n   = len_inc;
        end else if (cls == CLS_D) begin
          state_n = S_DIGIT;
          len_n   = len_inc;
        end
      end
      S_DIGIT: begin
        if (cls == CLS_D) begin
          state_n = S_DIGIT;
          len_n   = len_inc;
        end else if (cls == CLS_L) begin
          state_n = S_ALPHA;
          len_n   = LEN_W'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
        len_n   = '0;
      end
    endcase
    emit = (state == S_DIGIT) && (state_n != S_DIGIT);
  end

  id_len_fifo #(
    .WIDTH (LEN_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (emit),
    .din   (len),
    .pop   (tok.tok_ready),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (tok.tok_len)
  );

  assign tok.tok_valid = !fifo_empty;
  assign pop_eff       = tok.tok_ready && !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      tok_cnt <= '0;
      ovf     <= 1'b0;
    end else begin
      if (emit) tok_cnt <= tok_cnt + CNT_W'(1);
      if (emit && fifo_full && !pop_eff) ovf <= 1'b1;
    end
  end

`ifdef ID_TRK_XCHECK_EN
  logic armed;

  // Both machines are known idle once an 'other' char has been seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (cls == CLS_O) armed <= 1'b1;
      if (armed && (match != (state == S_DIGIT))) err <= 1'b1;
    end
  end
`else
  logic unused_match;
  assign unused_match = match;
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_id_token_tracker.sv
// Randomized bench for id_token_tracker against a queue-based token model.
module tb_id_token_tracker;
  localparam int unsigned LW = 4;
  localparam int unsigned DP = 4;
  localparam int unsigned CW = 16;
  localparam int LEN_SAT = (1 << LW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    chr = 8'h20;
  logic          match = 1'b0;
  logic [CW-1:0] tok_cnt;
  logic          ovf, err;

  id_token_tracker_if #(.LEN_W(LW)) tok_if ();

  id_token_tracker #(
    .LEN_W (LW),
    .DEPTH (DP),
    .CNT_W (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .char    (chr),
    .match   (match),
    .tok     (tok_if),
    .tok_cnt (tok_cnt),
    .ovf     (ovf),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: current candidate identifier text, queued lengths, sticky flags.
  logic [7:0] run[$];
  int         fifo_q[$];
  int         cnt_e;
  bit         ovf_e, err_e, armed_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit is_l(input logic [7:0] c);
    return (c inside {[8'h41:8'h5A], [8'h61:8'h7A]});
  endfunction

  function automatic bit is_d(input logic [7:0] c);
    return (c inside {[8'h30:8'h39]});
  endfunction

  function automatic bit in_digit_run();
    return (run.size() > 0) && is_d(run[run.size()-1]);
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".valid"}, 32'(tok_if.tok_valid), 32'(fifo_q.size() > 0));
    if (fifo_q.size() > 0) check({tag, ".len"}, 32'(tok_if.tok_len), 32'(fifo_q[0]));
    check({tag, ".cnt"}, 32'(tok_cnt), 32'(cnt_e % (1 << CW)));
    check({tag, ".ovf"}, 32'(ovf), 32'(ovf_e));
    check({tag, ".err"}, 32'(err), 32'(err_e));
  endtask

  task automatic step(input logic [7:0] c, input bit rdy, input bit force_m);
    bit emit, pop, in_dig;
    int elen;
    chr = c;
    tok_if.tok_ready = rdy;
    if (force_m) match = 1'b1;
    in_dig = in_digit_run();
    emit   = in_dig && !is_d(c);
    elen   = (run.size() > LEN_SAT) ? LEN_SAT : run.size();
    pop    = rdy && (fifo_q.size() > 0);
`ifdef ID_TRK_XCHECK_EN
    if (armed_e && (match != in_dig)) err_e = 1'b1;
    if (!is_l(c) && !is_d(c)) armed_e = 1'b1;
`endif
    if (is_l(c)) begin
      if (in_dig) run.delete();
      run.push_back(c);
    end else if (is_d(c)) begin
      if (run.size() > 0) run.push_back(c);
    end else begin
      run.delete();
    end
    if (pop) void'(fifo_q.pop_front());
    if (emit) begin
      cnt_e++;
      if (fifo_q.size() < DP) fifo_q.push_back(elen);
      else ovf_e = 1'b1;
    end
    @(posedge clk);
    #1;
    match = in_digit_run();
    compare_all("step");
  endtask

  task automatic send(input string s, input bit rdy);
    for (int i = 0; i < s.len(); i++) step(s[i], rdy, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DP + 2; i++) step(8'h20, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tok_if.tok_ready = 1'b0;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    match = 1'b0;
    run.delete();
    fifo_q.delete();
    cnt_e   = 0;
    ovf_e   = 1'b0;
    err_e   = 1'b0;
    armed_e = 1'b0;
    check("rst.len", 32'(tok_if.tok_len), 32'd0);
    compare_all("rst");
  endtask

  logic [7:0] alpha [10] = '{8'h61, 8'h5A, 8'h6D, 8'h30, 8'h39, 8'h35, 8'h20, 8'h3B, 8'h62, 8'h33};

  initial begin
    tok_if.tok_ready = 1'b0;
    do_reset();

    // Single token with consumer always ready.
    send("ab12 ", 1'b1);
    check("t1.cnt", 32'(tok_cnt), 32'd1);
    drain();

    // Back-to-back runs and non-identifiers.
    send("x9y7;", 1'b0);
    check("t2.head", 32'(tok_if.tok_len), 32'd2);
    drain();
    send("abc;12;", 1'b1);
    check("t2.cnt", 32'(tok_cnt), 32'd3);

    // Length saturation.
    for (int i = 0; i < 20; i++) step(8'h71, 1'b0, 1'b0);
    send("5 ", 1'b0);
    check("t3.sat", 32'(tok_if.tok_len), 32'(LEN_SAT));
    drain();

    // Overflow, then push and pop on the same edge while full.
    do_reset();
    for (int i = 0; i < 5; i++) send("a1 ", 1'b0);
    check("t4.ovf", 32'(ovf), 32'd1);
    check("t4.cnt", 32'(tok_cnt), 32'd5);
    send("a1", 1'b0);
    step(8'h20, 1'b1, 1'b0);
    check("t4.cnt6", 32'(tok_cnt), 32'd6);
    drain();

    // Reset mid-token discards the partial run.
    send("ab1", 1'b0);
    do_reset();
    send(" c2 ", 1'b0);
    check("t5.head", 32'(tok_if.tok_len), 32'd2);
    drain();

    // Forced match while the mirror is idle.
    step(8'h20, 1'b0, 1'b0);
    step(8'h20, 1'b0, 1'b1);
    step(8'h20, 1'b0, 1'b0);
`ifdef ID_TRK_XCHECK_EN
    check("t6.err", 32'(err), 32'd1);
`else
    check("t6.err", 32'(err), 32'd0);
`endif
    do_reset();

    // Random streams with random backpressure.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      else step(alpha[$urandom_range(0, 9)], ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 199) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
